// File: rtl/axi4_mgr_req_sched.sv
// Round-robin scheduler sharing one axi4_mgr among NUM_REQ requesters.
// Defining AXI4_SCHED_TIMEOUT_EN adds a watchdog that ends a transfer whose busy never rises.
//  state     | meaning
//  IDLE      | no transfer; arbitrate pending requests from ptr
//  ISSUE     | one-cycle accept pulse and manager request
//  WAIT_BSY  | wait for manager busy of the active direction to rise
//  WAIT_DONE | wait for that busy to fall, then report completion
module axi4_mgr_req_sched #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  done_o,
  output logic [1:0]                          err_o,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id_o,
  output logic                                active_o,
  output logic [1:0]                          mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_rd_addr_o,
  input  logic [1:0]                          mgr_busy_i,
  input  logic [1:0]                          mgr_wr_err_i,
  input  logic [1:0]                          mgr_rd_err_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = AXI_ADDR_WIDTH;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BSY  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [1:0]         mgr_req_q, mgr_req_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic               active_q, active_d;

  logic               gnt_found;
  logic [IW-1:0]      gnt_idx;
  logic [IW:0]        cand_sum;
  logic [IW-1:0]      gid_next;
  logic               busy_dir;
  logic               finish;
  logic [1:0]         finish_err;

`ifdef AXI4_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // First pending index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(NUM_REQ)) cand_sum = cand_sum - (IW+1)'(NUM_REQ);
      if (!gnt_found && req_valid_i[cand_sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[IW-1:0];
      end
    end
  end

  assign gid_next = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);
  assign busy_dir = wr_q ? mgr_busy_i[0] : mgr_busy_i[1];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    wr_d       = wr_q;
    ready_d    = '0;
    done_d     = '0;
    err_d      = err_q;
    mgr_req_d  = '0;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    active_d   = active_q;
    finish     = 1'b0;
    finish_err = err_q;
`ifdef AXI4_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d          = S_ISSUE;
          gid_d            = gnt_idx;
          wr_d             = req_write_i[gnt_idx];
          ready_d[gnt_idx] = 1'b1;
          active_d         = 1'b1;
          if (req_write_i[gnt_idx]) begin
            mgr_req_d = 2'b01;
            wr_addr_d = req_addr_i[gnt_idx*AW +: AW];
            rd_addr_d = '0;
          end else begin
            mgr_req_d = 2'b10;
            rd_addr_d = req_addr_i[gnt_idx*AW +: AW];
            wr_addr_d = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BSY;
`ifdef AXI4_SCHED_TIMEOUT_EN
        cnt_d   = CW'(TIMEOUT_CYCLES - 1);
`endif
      end
      S_WAIT_BSY: begin
        if (busy_dir) state_d = S_WAIT_DONE;
`ifdef AXI4_SCHED_TIMEOUT_EN
        else if (cnt_q == '0) begin
          finish     = 1'b1;
          finish_err = 2'b11;
        end else cnt_d = cnt_q - CW'(1);
`endif
      end
      S_WAIT_DONE: begin
        if (!busy_dir) begin
          finish     = 1'b1;
          finish_err = wr_q ? mgr_wr_err_i : mgr_rd_err_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d        = S_IDLE;
      active_d       = 1'b0;
      done_d[gid_q]  = 1'b1;
      err_d          = finish_err;
      ptr_d          = gid_next;
      wr_addr_d      = '0;
      rd_addr_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      wr_q      <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      mgr_req_q <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      active_q  <= 1'b0;
`ifdef AXI4_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mgr_req_q <= mgr_req_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      active_q  <= active_d;
`ifdef AXI4_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign req_ready_o   = ready_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign grant_id_o    = gid_q;
  assign active_o      = active_q;
  assign mgr_req_o     = mgr_req_q;
  assign mgr_wr_addr_o = wr_addr_q;
  assign mgr_rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_axi4_mgr_req_sched.sv
// Directed plus randomized bench for axi4_mgr_req_sched against a queue-free round-robin model.
// Timeout section follows AXI4_SCHED_TIMEOUT_EN like the design.
module tb_axi4_mgr_req_sched;
  localparam int N  = 4;
  localparam int AW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_write_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      done_o;
  logic [1:0]        err_o;
  logic [$clog2(N)-1:0] grant_id_o;
  logic              active_o;
  logic [1:0]        mgr_req_o;
  logic [AW-1:0]     mgr_wr_addr_o;
  logic [AW-1:0]     mgr_rd_addr_o;
  logic [1:0]        mgr_busy_i;
  logic [1:0]        mgr_wr_err_i;
  logic [1:0]        mgr_rd_err_i;

  int total = 0;
  int bad   = 0;
  int m_ptr;
  logic [1:0] m_err;

  axi4_mgr_req_sched #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .done_o(done_o), .err_o(err_o),
    .grant_id_o(grant_id_o), .active_o(active_o), .mgr_req_o(mgr_req_o),
    .mgr_wr_addr_o(mgr_wr_addr_o), .mgr_rd_addr_o(mgr_rd_addr_o),
    .mgr_busy_i(mgr_busy_i), .mgr_wr_err_i(mgr_wr_err_i), .mgr_rd_err_i(mgr_rd_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " ready"},   req_ready_o,   0);
    check({tag, " done"},    done_o,        0);
    check({tag, " err"},     err_o,         0);
    check({tag, " gid"},     grant_id_o,    0);
    check({tag, " active"},  active_o,      0);
    check({tag, " mgr_req"}, mgr_req_o,     0);
    check({tag, " wr_addr"}, mgr_wr_addr_o, 0);
    check({tag, " rd_addr"}, mgr_rd_addr_o, 0);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a);
    req_write_i[i]          = w;
    req_addr_i[i*AW +: AW]  = a;
    req_valid_i[i]          = 1'b1;
  endtask

  // One full transfer from IDLE; manager behaviour driven here with busy delay/length.
  task automatic run_xfer(input string tag, input int dly, input int blen,
                          input logic [1:0] err, input int late_req, output int g);
    int eg;
    logic w;
    logic [AW-1:0] a;
    eg = rr_pick(m_ptr, req_valid_i);
    if (eg < 0) eg = 0;
    w = req_write_i[eg];
    a = req_addr_i[eg*AW +: AW];
    step();
    check({tag, " ready"},   req_ready_o, 64'd1 << eg);
    check({tag, " mgr_req"}, mgr_req_o, w ? 2'b01 : 2'b10);
    check({tag, " wr_addr"}, mgr_wr_addr_o, w ? a : '0);
    check({tag, " rd_addr"}, mgr_rd_addr_o, w ? '0 : a);
    check({tag, " gid"},     grant_id_o, eg);
    check({tag, " active"},  active_o, 1);
    check({tag, " err_hold"}, err_o, m_err);
    req_valid_i[eg] = 1'b0;
    step();
    check({tag, " ready_clr"}, req_ready_o, 0);
    check({tag, " req_clr"},   mgr_req_o, 0);
    check({tag, " addr_hold"}, w ? mgr_wr_addr_o : mgr_rd_addr_o, a);
    for (int d = 0; d < dly; d++) begin
      mgr_busy_i = w ? 2'b10 : 2'b01;
      step();
    end
    mgr_busy_i = w ? 2'b01 : 2'b10;
    step();
    for (int b = 0; b < blen - 1; b++) step();
    check({tag, " no_early_done"}, done_o, 0);
    check({tag, " active_wait"},   active_o, 1);
    mgr_busy_i   = 2'b00;
    mgr_wr_err_i = w ? err : ~err;
    mgr_rd_err_i = w ? ~err : err;
    if (late_req >= 0) req_valid_i[late_req] = 1'b1;
    step();
    check({tag, " done"},   done_o, 64'd1 << eg);
    check({tag, " err"},    err_o, err);
    check({tag, " idle"},   active_o, 0);
    m_ptr = (eg + 1) % N;
    m_err = err;
    g = eg;
  endtask

  initial begin
    int g;
    logic [N-1:0] nw;
    rst_i = 1'b1;
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0;
    mgr_busy_i = '0; mgr_wr_err_i = '0; mgr_rd_err_i = '0;
    m_ptr = 0; m_err = 2'b00;
    step(); step();
    check_all_zero("reset");
    rst_i = 1'b0;
    step(); step();
    check("idle_no_req active", active_o, 0);
    check("idle_no_req ready",  req_ready_o, 0);

    // T1 single write
    set_req(0, 1'b1, 32'h5000);
    run_xfer("t1", 1, 8, 2'b00, -1, g);
    check("t1 grant", g, 0);

    // reset so round-robin starts from 0 again
    rst_i = 1'b1; step(); rst_i = 1'b0; m_ptr = 0; m_err = 2'b00;
    check("rst2 err", err_o, 0);

    // T2 round-robin with wrap
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), 32'h1000 * (i + 1));
    for (int i = 0; i < N; i++) begin
      run_xfer("t2", i, 2, 2'(i), -1, g);
      check("t2 order", g, i);
    end
    set_req(0, 1'b0, 32'hABC0);
    run_xfer("t2wrap", 0, 1, 2'b01, -1, g);
    check("t2 wrap grant", g, 0);

    // T3 read with error
    set_req(2, 1'b0, 32'h6000);
    run_xfer("t3", 2, 3, 2'b10, -1, g);
    check("t3 grant", g, 2);

    // T6 new request arrives as busy falls
    set_req(1, 1'b1, 32'h7100);
    req_write_i[3] = 1'b0; req_addr_i[3*AW +: AW] = 32'h7300;
    run_xfer("t6a", 0, 2, 2'b00, 3, g);
    check("t6 first", g, 1);
    run_xfer("t6b", 0, 1, 2'b01, -1, g);
    check("t6 second", g, 3);

    // T4 reset in WAIT_DONE
    set_req(2, 1'b1, 32'h8200);
    step();
    check("t4 ready", req_ready_o, 4'b0100);
    req_valid_i[2] = 1'b0;
    step();
    mgr_busy_i = 2'b01;
    step(); step();
    check("t4 in_wait", active_o, 1);
    rst_i = 1'b1;
    mgr_busy_i = 2'b00;
    step();
    check_all_zero("t4");
    rst_i = 1'b0;
    m_ptr = 0; m_err = 2'b00;
    step();
    check("t4 no_done", done_o, 0);
    set_req(1, 1'b0, 32'h9100);
    run_xfer("t4post", 0, 2, 2'b00, -1, g);
    check("t4 grant", g, 1);

    // T5 busy never rises
    set_req(0, 1'b1, 32'hA000);
    step();
    req_valid_i[0] = 1'b0;
    step();
`ifdef AXI4_SCHED_TIMEOUT_EN
    for (int c = 0; c < 15; c++) step();
    check("t5 before_to", done_o, 0);
    step();
    check("t5 done", done_o, 4'b0001);
    check("t5 err",  err_o, 2'b11);
    m_ptr = 1; m_err = 2'b11;
`else
    for (int c = 0; c < 40; c++) step();
    check("t5 still_active", active_o, 1);
    check("t5 no_done", done_o, 0);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    m_ptr = 0; m_err = 2'b00;
`endif
    step();

    // randomized traffic against the round-robin model
    for (int it = 0; it < 40; it++) begin
      nw = N'($urandom_range(0, (1 << N) - 1)) & ~req_valid_i;
      if ((req_valid_i | nw) == '0) nw[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++)
        if (nw[i]) set_req(i, 1'($urandom_range(0, 1)), $urandom);
      run_xfer("rnd", $urandom_range(0, 4), $urandom_range(1, 5),
               2'($urandom_range(0, 3)), -1, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end
endmodule
